// File: rtl/minmax_pkg.sv
// Shared definitions for the window min/max tracker.
// Holds the FSM state encoding and the width-derivation helper.
package minmax_pkg;

  // Two-state FSM: accumulate samples, then hold the window result.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Ceiling log2 for deriving index and tie-count widths.
  // Returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/n_bit_comparator.sv
// Unsigned N-bit magnitude comparator.
// Purely combinational; produces all three relations of A against B.
module n_bit_comparator #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         A_gt_B,
  output logic         A_eq_B,
  output logic         A_lt_B
);

  assign A_gt_B = (A > B);
  assign A_eq_B = (A == B);
  assign A_lt_B = (A < B);

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks max/min, first-occurrence indices and max tie count over a fixed
// window of WIN samples. The result is held on a valid/ready output until
// the consumer takes it; no samples are accepted while it is held.
module window_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int N   = 4,
  parameter int WIN = 4,
  parameter int IW  = clog2(WIN),
  parameter int CW  = clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  max_val,
  output logic [N-1:0]  min_val,
  output logic [IW-1:0] max_idx,
  output logic [IW-1:0] min_idx,
  output logic [CW-1:0] max_ties
);

  state_e        state_q, state_d;
  logic [IW-1:0] count_q, count_d;
  logic [N-1:0]  max_q, max_d;
  logic [N-1:0]  min_q, min_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic [CW-1:0] ties_q, ties_d;

  logic max_gt, max_eq, min_lt;

  // Incoming sample against the stored maximum.
  n_bit_comparator #(.N(N)) u_cmp_max (
    .A      (in_data),
    .B      (max_q),
    .A_gt_B (max_gt),
    .A_eq_B (max_eq),
    .A_lt_B ()
  );

  // Incoming sample against the stored minimum.
  n_bit_comparator #(.N(N)) u_cmp_min (
    .A      (in_data),
    .B      (min_q),
    .A_gt_B (),
    .A_eq_B (),
    .A_lt_B (min_lt)
  );

  // Handshake outputs decode straight from the state flop, so neither
  // depends combinationally on in_valid or out_ready.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign max_idx   = max_idx_q;
  assign min_idx   = min_idx_q;
  assign max_ties  = ties_q;

  // Next-state and result update: first sample loads, later samples refine.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    ties_d    = ties_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (count_q == '0) begin
            max_d     = in_data;
            min_d     = in_data;
            max_idx_d = '0;
            min_idx_d = '0;
            ties_d    = CW'(1);
          end else begin
            // Strictly greater moves the max; equal only bumps the tie count
            // so the earliest index is kept.
            if (max_gt) begin
              max_d     = in_data;
              max_idx_d = count_q;
              ties_d    = CW'(1);
            end else if (max_eq) begin
              ties_d = ties_q + CW'(1);
            end
            if (min_lt) begin
              min_d     = in_data;
              min_idx_d = count_q;
            end
          end
          if (count_q == IW'(WIN - 1)) begin
            count_d = '0;
            state_d = ST_HOLD;
          end else begin
            count_d = count_q + IW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      count_q   <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      ties_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      ties_q    <= ties_d;
    end
  end

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Testbench for window_minmax_tracker: directed windows, a per-cycle
// comparison against a window-level model, and literal pinned results.
module tb_window_minmax_tracker;

  localparam int N   = 4;
  localparam int WIN = 4;
  localparam int IW  = 2;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  max_val;
  logic [N-1:0]  min_val;
  logic [IW-1:0] max_idx;
  logic [IW-1:0] min_idx;
  logic [CW-1:0] max_ties;

  int vectors = 0;
  int errors  = 0;

  window_minmax_tracker #(.N(N), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .max_ties  (max_ties)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int mx;
    int mn;
    int mxi;
    int mni;
    int ties;
  } res_t;

  // Window result from the full list of samples: scan for extremes keeping
  // the earliest position, then count how many samples equal the maximum.
  function automatic res_t eval_window(input int s[WIN]);
    res_t r;
    r.mx = s[0]; r.mn = s[0]; r.mxi = 0; r.mni = 0; r.ties = 0;
    for (int i = 1; i < WIN; i++) begin
      if (s[i] > r.mx) begin r.mx = s[i]; r.mxi = i; end
      if (s[i] < r.mn) begin r.mn = s[i]; r.mni = i; end
    end
    for (int i = 0; i < WIN; i++) begin
      if (s[i] == r.mx) r.ties++;
    end
    return r;
  endfunction

  bit   m_valid = 0;
  bit   m_hold  = 0;
  bit   m_fresh = 0;
  int   m_cnt   = 0;
  int   m_buf[WIN];
  int   m_tmp[WIN];
  res_t m_res;
  int   e_max = 0, e_min = 0, e_mxi = 0, e_mni = 0, e_ties = 0;

  // Model advances on each rising edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1; m_hold <= 0; m_cnt <= 0; m_fresh <= 1;
      e_max <= 0; e_min <= 0; e_mxi <= 0; e_mni <= 0; e_ties <= 0;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 0;
    end else if (in_valid) begin
      m_fresh <= 0;
      if (m_cnt == WIN - 1) begin
        m_tmp = m_buf;
        m_tmp[WIN-1] = int'(in_data);
        m_res = eval_window(m_tmp);
        e_max <= m_res.mx; e_min <= m_res.mn;
        e_mxi <= m_res.mxi; e_mni <= m_res.mni; e_ties <= m_res.ties;
        $display("window %0d %0d %0d %0d -> max=%0d@%0d ties=%0d min=%0d@%0d",
                 m_tmp[0], m_tmp[1], m_tmp[2], m_tmp[3],
                 m_res.mx, m_res.mxi, m_res.ties, m_res.mn, m_res.mni);
        m_hold <= 1;
        m_cnt  <= 0;
      end else begin
        m_buf[m_cnt] <= int'(in_data);
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Compare process: handshake every cycle, results whenever defined.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold || m_fresh) begin
        chk("max_val", 32'(max_val), e_max);
        chk("min_val", 32'(min_val), e_min);
        chk("max_idx", 32'(max_idx), e_mxi);
        chk("min_idx", 32'(min_idx), e_mni);
        chk("max_ties", 32'(max_ties), e_ties);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Apply inputs, let one rising edge pass, return 2 time units after it.
  task automatic step(input logic v, input int d, input logic ordy);
    in_valid  = v;
    in_data   = N'(d);
    out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string tag, input int mx, input int mxi, input int mn,
                     input int mni, input int ties);
    chk({tag, ".out_valid"}, 32'(out_valid), 1);
    chk({tag, ".max_val"},   32'(max_val), mx);
    chk({tag, ".max_idx"},   32'(max_idx), mxi);
    chk({tag, ".min_val"},   32'(min_val), mn);
    chk({tag, ".min_idx"},   32'(min_idx), mni);
    chk({tag, ".max_ties"},  32'(max_ties), ties);
  endtask

  int t1[4] = '{5, 3, 9, 1};
  int t2[4] = '{7, 7, 2, 7};
  int t3[4] = '{0, 15, 15, 0};
  int t6a[4] = '{3, 2, 1, 0};
  int t6b[4] = '{0, 1, 2, 3};

  initial begin
    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("reset.in_ready", 32'(in_ready), 1);
    chk("reset.out_valid", 32'(out_valid), 0);
    chk("reset.max_ties", 32'(max_ties), 0);
    rst_n = 1;

    // 1: basic window
    for (int i = 0; i < 4; i++) step(1, t1[i], 0);
    pin("t1", 9, 2, 1, 3, 1);
    step(0, 0, 1);
    chk("t1.release", 32'(out_valid), 0);

    // 2: ties
    for (int i = 0; i < 4; i++) step(1, t2[i], 0);
    pin("t2", 7, 0, 2, 2, 3);
    step(0, 0, 1);

    // 3: extremes, then backpressure with a sample waiting
    for (int i = 0; i < 4; i++) step(1, t3[i], 0);
    pin("t3", 15, 1, 0, 0, 2);
    for (int i = 0; i < 3; i++) step(1, 8, 0);
    pin("t3.hold", 15, 1, 0, 0, 2);
    chk("t3.hold.in_ready", 32'(in_ready), 0);
    step(1, 8, 1);
    chk("t3.ret.out_valid", 32'(out_valid), 0);
    chk("t3.ret.in_ready", 32'(in_ready), 1);
    step(1, 8, 0);
    chk("t3.idx0.max_val", 32'(max_val), 8);
    chk("t3.idx0.max_idx", 32'(max_idx), 0);
    step(1, 10, 0);
    step(1, 8, 0);
    step(1, 3, 0);
    pin("t3b", 10, 1, 3, 3, 1);
    step(0, 0, 1);

    // 4: bubbles
    step(1, 6, 0); step(0, 9, 0); step(1, 2, 0);
    step(0, 0, 0); step(0, 15, 0); step(1, 6, 0); step(1, 4, 0);
    pin("t4", 6, 0, 2, 1, 2);
    step(0, 0, 1);

    // 5: reset mid-window
    step(1, 1, 0); step(1, 14, 0);
    rst_n = 0;
    step(0, 0, 0);
    chk("t5.rst.max_val", 32'(max_val), 0);
    chk("t5.rst.min_val", 32'(min_val), 0);
    chk("t5.rst.max_ties", 32'(max_ties), 0);
    chk("t5.rst.in_ready", 32'(in_ready), 1);
    rst_n = 1;
    for (int i = 0; i < 4; i++) step(1, 4, 0);
    pin("t5", 4, 0, 4, 0, 4);
    step(0, 0, 1);

    // 6: back-to-back windows, out_ready held high
    for (int i = 0; i < 4; i++) step(1, t6a[i], 1);
    pin("t6a", 3, 0, 0, 3, 1);
    step(0, 0, 1);
    chk("t6a.one_cycle", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) step(1, t6b[i], 1);
    pin("t6b", 3, 3, 0, 0, 1);
    step(0, 0, 1);
    chk("t6b.one_cycle", 32'(out_valid), 0);
    step(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
